// File: rtl/block_hit_checker_pkg.sv
// Shared types and constants for the block loader / hit checker pair.
// Holds the window depth, time width, empty-slot marker, direction and
// colour encodings, and a small absolute-difference helper.
package block_hit_checker_pkg;

  localparam int NUM_BLOCKS = 12;
  localparam int IDX_W      = $clog2(NUM_BLOCKS);
  localparam int TIME_W     = 18;
  localparam int POS_W      = 12;

  localparam logic [TIME_W-1:0] EMPTY_TIME = 18'h3FFFF;

  typedef enum logic [2:0] {
    DIR_UP    = 3'd0,
    DIR_RIGHT = 3'd1,
    DIR_DOWN  = 3'd2,
    DIR_LEFT  = 3'd3,
    DIR_ANY   = 3'd4
  } dir_e;

  typedef enum logic {
    COLOR_BLUE = 1'b0,
    COLOR_RED  = 1'b1
  } color_e;

  // Identity of a block for "already scored" purposes.
  typedef struct packed {
    logic [TIME_W-1:0] blk_time;
    logic              color;
  } scored_key_t;

  // |a-b| on 12-bit unsigned positions, using a 13-bit difference so the
  // sign bit is never lost.
  function automatic logic [POS_W:0] abs_diff(input logic [POS_W-1:0] a,
                                              input logic [POS_W-1:0] b);
    logic [POS_W:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[POS_W] ? ((POS_W+1)'(0) - d) : d;
  endfunction

endpackage

// File: rtl/block_hit_checker_scored_table.sv
// Small table of recently scored blocks, keyed by {time, colour}.
// Ports: clk_in/rst_in; wr_en_i/wr_key_i append an entry (round-robin,
// oldest overwritten); scan_key_i/scan_hit_o and head_key_i/head_hit_o are
// two independent combinational lookups.
module block_scored_table
  import block_hit_checker_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        wr_en_i,
  input  scored_key_t wr_key_i,
  input  scored_key_t scan_key_i,
  output logic        scan_hit_o,
  input  scored_key_t head_key_i,
  output logic        head_hit_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  scored_key_t            entry_q [DEPTH];
  logic [DEPTH-1:0]       valid_q;
  logic [PTR_W-1:0]       wr_ptr_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
    end else if (wr_en_i) begin
      entry_q[wr_ptr_q] <= wr_key_i;
      valid_q[wr_ptr_q] <= 1'b1;
      wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
    end
  end

  always_comb begin
    scan_hit_o = 1'b0;
    head_hit_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && entry_q[i] == scan_key_i) scan_hit_o = 1'b1;
      if (valid_q[i] && entry_q[i] == head_key_i) head_hit_o = 1'b1;
    end
  end

endmodule

// File: rtl/block_hit_checker.sv
// Per-frame saber/block hit scanner with miss detection, score and combo.
// Ports: frame_start_in starts a 12-slot scan of a snapshot of the block
// window, sabers and time; hit_*_out pulse per hit, miss_out pulses when an
// unscored head block leaves slot 0; score/combo are running totals;
// scan_done_out pulses NUM_BLOCKS+1 cycles after the strobe edge.
module block_hit_checker
  import block_hit_checker_pkg::*;
#(
  parameter logic [TIME_W-1:0] HIT_WINDOW   = 18'd20,
  parameter logic [POS_W-1:0]  HIT_RADIUS   = 12'd64,
  parameter int                SCORED_DEPTH = 4
) (
  input  logic                                 clk_in,
  input  logic                                 rst_in,
  input  logic                                 frame_start_in,
  input  logic [TIME_W-1:0]                    curr_time_in,
  input  logic [NUM_BLOCKS-1:0][POS_W-1:0]     block_x_in,
  input  logic [NUM_BLOCKS-1:0][POS_W-1:0]     block_y_in,
  input  logic [NUM_BLOCKS-1:0][TIME_W-1:0]    block_time_in,
  input  logic [NUM_BLOCKS-1:0]                block_color_in,
  input  logic [NUM_BLOCKS-1:0][2:0]           block_direction_in,
  input  logic [1:0][POS_W-1:0]                saber_x_in,
  input  logic [1:0][POS_W-1:0]                saber_y_in,
  input  logic [1:0][2:0]                      saber_dir_in,
  input  logic [1:0]                           saber_dir_valid_in,
  output logic                                 hit_valid_out,
  output logic [IDX_W-1:0]                     hit_index_out,
  output logic                                 hit_color_out,
  output logic                                 miss_out,
  output logic [15:0]                          score_out,
  output logic [7:0]                           combo_out,
  output logic                                 scan_done_out
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_e;

  state_e                              state_q;
  logic [IDX_W-1:0]                    idx_q;

  // Frame snapshot so the scan sees one consistent picture.
  logic [TIME_W-1:0]                   snap_time_q;
  logic [NUM_BLOCKS-1:0][POS_W-1:0]    snap_bx_q, snap_by_q;
  logic [NUM_BLOCKS-1:0][TIME_W-1:0]   snap_bt_q;
  logic [NUM_BLOCKS-1:0]               snap_bc_q;
  logic [NUM_BLOCKS-1:0][2:0]          snap_bd_q;
  logic [1:0][POS_W-1:0]               snap_sx_q, snap_sy_q;
  logic [1:0][2:0]                     snap_sd_q;
  logic [1:0]                          snap_sv_q;

  logic [TIME_W-1:0]                   head_time_q;
  logic                                head_color_q;
  logic [15:0]                         score_q;
  logic [7:0]                          combo_q;

  // Current slot under evaluation
  logic [TIME_W-1:0] slot_time;
  logic [POS_W-1:0]  slot_x, slot_y, sab_x, sab_y;
  logic              slot_color;
  logic [2:0]        slot_dir;
  logic [TIME_W:0]   t19, c19, win_lo;
  logic              in_window, in_reach, dir_ok;
  logic              scan_scored, head_scored;
  logic              hit_d, miss_d;
  logic [7:0]        combo_base, combo_d;
  logic [3:0]        bonus;
  logic [16:0]       score_sum;
  logic [15:0]       score_d;

  always_comb begin
    slot_time  = snap_bt_q[idx_q];
    slot_x     = snap_bx_q[idx_q];
    slot_y     = snap_by_q[idx_q];
    slot_color = snap_bc_q[idx_q];
    slot_dir   = snap_bd_q[idx_q];
    sab_x      = snap_sx_q[slot_color];
    sab_y      = snap_sy_q[slot_color];

    // Low bound clamps at 0 instead of wrapping for very early blocks.
    t19    = {1'b0, slot_time};
    c19    = {1'b0, snap_time_q};
    win_lo = (t19 >= {1'b0, HIT_WINDOW}) ? (t19 - {1'b0, HIT_WINDOW}) : '0;
    in_window = (c19 >= win_lo) && (c19 <= t19);

    in_reach = (abs_diff(slot_x, sab_x) <= {1'b0, HIT_RADIUS}) &&
               (abs_diff(slot_y, sab_y) <= {1'b0, HIT_RADIUS});

    dir_ok = snap_sv_q[slot_color] &&
             ((slot_dir == DIR_ANY) || (slot_dir == snap_sd_q[slot_color]));

    hit_d = (state_q == S_SCAN) && (slot_time != EMPTY_TIME) &&
            in_window && in_reach && dir_ok && !scan_scored;

    // Miss runs on live inputs every cycle, regardless of scan state.
    miss_d = (block_time_in[0] != head_time_q) && (head_time_q != EMPTY_TIME) &&
             !head_scored;

    // A same-cycle miss breaks the combo before the hit is scored.
    combo_base = miss_d ? 8'd0 : combo_q;
    bonus      = (combo_base > 8'd7) ? 4'd8 : (combo_base[3:0] + 4'd1);
    score_sum  = {1'b0, score_q} + {13'd0, bonus};

    score_d = score_q;
    combo_d = combo_base;
    if (hit_d) begin
      score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
      combo_d = (combo_base == 8'hFF) ? 8'hFF : combo_base + 8'd1;
    end
  end

  block_scored_table #(
    .DEPTH(SCORED_DEPTH)
  ) u_scored (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .wr_en_i    (hit_d),
    .wr_key_i   ('{blk_time: slot_time, color: slot_color}),
    .scan_key_i ('{blk_time: slot_time, color: slot_color}),
    .scan_hit_o (scan_scored),
    .head_key_i ('{blk_time: head_time_q, color: head_color_q}),
    .head_hit_o (head_scored)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      snap_time_q   <= '0;
      snap_bx_q     <= '0;
      snap_by_q     <= '0;
      snap_bt_q     <= '0;
      snap_bc_q     <= '0;
      snap_bd_q     <= '0;
      snap_sx_q     <= '0;
      snap_sy_q     <= '0;
      snap_sd_q     <= '0;
      snap_sv_q     <= '0;
      head_time_q   <= EMPTY_TIME;
      head_color_q  <= 1'b0;
      score_q       <= '0;
      combo_q       <= '0;
      hit_valid_out <= 1'b0;
      hit_index_out <= '0;
      hit_color_out <= 1'b0;
      miss_out      <= 1'b0;
      scan_done_out <= 1'b0;
    end else begin
      hit_valid_out <= hit_d;
      if (hit_d) begin
        hit_index_out <= idx_q;
        hit_color_out <= slot_color;
      end
      miss_out      <= miss_d;
      head_time_q   <= block_time_in[0];
      head_color_q  <= block_color_in[0];
      score_q       <= score_d;
      combo_q       <= combo_d;
      scan_done_out <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (frame_start_in) begin
            snap_time_q <= curr_time_in;
            snap_bx_q   <= block_x_in;
            snap_by_q   <= block_y_in;
            snap_bt_q   <= block_time_in;
            snap_bc_q   <= block_color_in;
            snap_bd_q   <= block_direction_in;
            snap_sx_q   <= saber_x_in;
            snap_sy_q   <= saber_y_in;
            snap_sd_q   <= saber_dir_in;
            snap_sv_q   <= saber_dir_valid_in;
            idx_q       <= '0;
            state_q     <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (idx_q == IDX_W'(NUM_BLOCKS-1)) state_q <= S_DONE;
          else                               idx_q   <= idx_q + 1'b1;
        end
        S_DONE: begin
          scan_done_out <= 1'b1;
          state_q       <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign score_out = score_q;
  assign combo_out = combo_q;

endmodule
